// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan driver. A loaded word is held in staging and moves to the
// displayed shadow at a frame boundary. Every digit change is followed by a blanking gap.
module seg_scan_driver #(
  parameter int unsigned BLANK_CYC = 15,
  parameter bit          LZS       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        pending,
  output logic        upd_ack
);

  localparam logic [7:0] BlankInit = 8'(BLANK_CYC);

  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stage_v_q, stage_v_d, shad_v_q, shad_v_d;
  logic [3:0]  stage_dp_q, stage_dp_d, shad_dp_q, shad_dp_d;
  logic        pending_q, pending_d;
  logic        upd_ack_q, upd_ack_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;

  logic        sel_change, frame;
  logic [3:0]  digit;
  logic [3:0]  supp;

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign sel_change = (sel != sel_q);
  assign frame      = sel_change && (sel == 2'b00);
  assign digit      = shad_v_q[{sel_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    supp    = 4'b0000;
    supp[3] = LZS && (shad_v_q[15:12] == 4'h0);
    supp[2] = supp[3] && (shad_v_q[11:8] == 4'h0);
    supp[1] = supp[2] && (shad_v_q[7:4] == 4'h0);
  end

  always_comb begin
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    stage_v_d  = stage_v_q;
    stage_dp_d = stage_dp_q;
    shad_v_d   = shad_v_q;
    shad_dp_d  = shad_dp_q;
    pending_d  = pending_q;
    upd_ack_d  = 1'b0;
    an_d       = 4'hF;
    seg_d      = 7'h7F;
    dp_n_d     = 1'b1;

    if (load) begin
      stage_v_d  = value;
      stage_dp_d = dp;
      if (frame) begin
        // Load on the boundary bypasses staging entirely.
        shad_v_d  = value;
        shad_dp_d = dp;
        pending_d = 1'b0;
        upd_ack_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame && pending_q) begin
      shad_v_d  = stage_v_q;
      shad_dp_d = stage_dp_q;
      pending_d = 1'b0;
      upd_ack_d = 1'b1;
    end

    if (sel_change) begin
      sel_d = sel;
      cnt_d = BlankInit;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else if (en) begin
      an_d   = ~(4'b0001 << sel_q);
      seg_d  = supp[sel_q] ? 7'h7F : decode(digit);
      dp_n_d = ~shad_dp_q[sel_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= 2'b00;
      cnt_q      <= BlankInit;
      stage_v_q  <= 16'h0000;
      stage_dp_q <= 4'h0;
      shad_v_q   <= 16'h0000;
      shad_dp_q  <= 4'h0;
      pending_q  <= 1'b0;
      upd_ack_q  <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_n_q     <= 1'b1;
    end else begin
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      stage_v_q  <= stage_v_d;
      stage_dp_q <= stage_dp_d;
      shad_v_q   <= shad_v_d;
      shad_dp_q  <= shad_dp_d;
      pending_q  <= pending_d;
      upd_ack_q  <= upd_ack_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp_n    = dp_n_q;
  assign pending = pending_q;
  assign upd_ack = upd_ack_q;

endmodule
